// File: rtl/alu_wide_pkg.sv
// Shared definitions for the wide accumulator ALU: op encodings, nibble width,
// FSM state encoding and the keyboard-process (KBP) nibble map.
package alu_wide_pkg;

  localparam int NIB = 4;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_XCH = 4'd2;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_IAC = 4'd5;
  localparam logic [3:0] OP_DAC = 4'd6;
  localparam logic [3:0] OP_CLB = 4'd7;
  localparam logic [3:0] OP_CMA = 4'd8;
  localparam logic [3:0] OP_CMC = 4'd9;
  localparam logic [3:0] OP_RAL = 4'd10;
  localparam logic [3:0] OP_RAR = 4'd11;
  localparam logic [3:0] OP_TCC = 4'd12;
  localparam logic [3:0] OP_DAA = 4'd13;
  localparam logic [3:0] OP_KBP = 4'd14;
  localparam logic [3:0] OP_DCL = 4'd15;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_DAA_RUN = 1'b1
  } state_t;

  // One-hot key code to key number; anything not one-hot (except 0) is an error code F.
  function automatic logic [NIB-1:0] kbp_map(input logic [NIB-1:0] n);
    logic [NIB-1:0] r;
    case (n)
      4'h0:    r = 4'h0;
      4'h1:    r = 4'h1;
      4'h2:    r = 4'h2;
      4'h4:    r = 4'h3;
      4'h8:    r = 4'h4;
      default: r = 4'hF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_wide_daa_nib.sv
// One nibble of decimal adjust: add incoming carry, then add 6 when the
// digit overflowed decimal range or the adjust is forced.
module alu_wide_daa_nib
  import alu_wide_pkg::*;
(
  input  logic [NIB-1:0] nib,
  input  logic           cin,
  input  logic           force6,
  output logic [NIB-1:0] nib_out,
  output logic           cout
);

  logic [NIB:0] s;
  logic [NIB:0] adj;

  always_comb begin
    s       = {1'b0, nib} + {{NIB{1'b0}}, cin};
    adj     = ((s > 5'd9) || force6) ? s + 5'd6 : s;
    nib_out = adj[NIB-1:0];
    cout    = adj[NIB];
  end

endmodule

// File: rtl/alu_wide.sv
// Parametrised 4004-class accumulator/carry datapath with a multi-cycle
// nibble-serial decimal adjust and DCL-style one-hot CMRAM bank select.
module alu_wide
  import alu_wide_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NBANKS = 4
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_code,
  input  logic [WIDTH-1:0]  op_data,
  output logic              res_valid,
  output logic [WIDTH-1:0]  acc,
  output logic              cy,
  output logic              acc_zero,
  output logic [WIDTH-1:0]  data_out,
  input  logic              com_n,
  output logic [NBANKS-1:0] cmram,
  output logic              cmrom
);

  localparam int NNIB   = WIDTH / NIB;
  localparam int BANK_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int K_W    = (NNIB > 1) ? $clog2(NNIB) : 1;

  state_t             state_q, state_nxt;
  logic [WIDTH-1:0]   acc_q, acc_nxt;
  logic               cy_q, cy_nxt;
  logic [WIDTH-1:0]   dout_q, dout_nxt;
  logic [BANK_W-1:0]  bank_q, bank_nxt;
  logic [K_W-1:0]     k_q, k_nxt;
  logic               cin_q, cin_nxt;
  logic               rv_q, rv_nxt;

  int                 nib_idx;
  logic [NIB-1:0]     daa_nib_in;
  logic [NIB-1:0]     daa_nib_out;
  logic               daa_cin;
  logic               daa_force6;
  logic               daa_cout;
  logic               daa_last;
  logic [WIDTH-1:0]   daa_acc;
  logic [WIDTH:0]     wide;

  // Nibble 0 is handled on the accepting edge (carry-in 0, forced by cy);
  // later nibbles take the carry latched from the previous one.
  always_comb begin
    nib_idx    = (state_q == ST_IDLE) ? 0 : int'(k_q);
    daa_nib_in = acc_q[nib_idx*NIB +: NIB];
    daa_cin    = (state_q == ST_IDLE) ? 1'b0 : cin_q;
    daa_force6 = (state_q == ST_IDLE) ? cy_q : 1'b0;
    daa_last   = (k_q == K_W'(NNIB - 1));
  end

  alu_wide_daa_nib u_daa_nib (
    .nib     (daa_nib_in),
    .cin     (daa_cin),
    .force6  (daa_force6),
    .nib_out (daa_nib_out),
    .cout    (daa_cout)
  );

  always_comb begin
    state_nxt = state_q;
    acc_nxt   = acc_q;
    cy_nxt    = cy_q;
    dout_nxt  = dout_q;
    bank_nxt  = bank_q;
    k_nxt     = k_q;
    cin_nxt   = cin_q;
    rv_nxt    = 1'b0;
    wide      = '0;
    daa_acc   = acc_q;
    daa_acc[nib_idx*NIB +: NIB] = daa_nib_out;

    if (state_q == ST_DAA_RUN) begin
      acc_nxt = daa_acc;
      if (daa_last) begin
        state_nxt = ST_IDLE;
        rv_nxt    = 1'b1;
        if (daa_cout) cy_nxt = 1'b1;
      end else begin
        k_nxt   = k_q + 1'b1;
        cin_nxt = daa_cout;
      end
    end else if (op_valid) begin
      rv_nxt = 1'b1;
      case (op_code)
        OP_NOP: ;
        OP_LD:  acc_nxt = op_data;
        OP_XCH: begin
          acc_nxt  = op_data;
          dout_nxt = acc_q;
        end
        OP_ADD: begin
          wide = {1'b0, acc_q} + {1'b0, op_data} + {{WIDTH{1'b0}}, cy_q};
          {cy_nxt, acc_nxt} = wide;
        end
        OP_SUB: begin
          wide = {1'b0, acc_q} + {1'b0, ~op_data} + {{WIDTH{1'b0}}, ~cy_q};
          {cy_nxt, acc_nxt} = wide;
        end
        OP_IAC: begin
          wide = {1'b0, acc_q} + {{WIDTH{1'b0}}, 1'b1};
          {cy_nxt, acc_nxt} = wide;
        end
        OP_DAC: begin
          acc_nxt = acc_q - {{(WIDTH-1){1'b0}}, 1'b1};
          cy_nxt  = (acc_q != '0);
        end
        OP_CLB: begin
          acc_nxt = '0;
          cy_nxt  = 1'b0;
        end
        OP_CMA: acc_nxt = ~acc_q;
        OP_CMC: cy_nxt = ~cy_q;
        OP_RAL: {cy_nxt, acc_nxt} = {acc_q, cy_q};
        OP_RAR: {acc_nxt, cy_nxt} = {cy_q, acc_q};
        OP_TCC: begin
          acc_nxt = {{(WIDTH-1){1'b0}}, cy_q};
          cy_nxt  = 1'b0;
        end
        OP_DAA: begin
          acc_nxt = daa_acc;
          if (NNIB == 1) begin
            if (daa_cout) cy_nxt = 1'b1;
          end else begin
            state_nxt = ST_DAA_RUN;
            rv_nxt    = 1'b0;
            k_nxt     = K_W'(1);
            cin_nxt   = daa_cout;
          end
        end
        OP_KBP: begin
          acc_nxt = '0;
          acc_nxt[NIB-1:0] = kbp_map(acc_q[NIB-1:0]);
        end
        OP_DCL: bank_nxt = acc_q[BANK_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      dout_q  <= '0;
      bank_q  <= '0;
      k_q     <= '0;
      cin_q   <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      acc_q   <= acc_nxt;
      cy_q    <= cy_nxt;
      dout_q  <= dout_nxt;
      bank_q  <= bank_nxt;
      k_q     <= k_nxt;
      cin_q   <= cin_nxt;
      rv_q    <= rv_nxt;
    end
  end

  // Bank codes beyond NBANKS-1 match no line, so all cmram stay low.
  always_comb begin
    cmram = '0;
    for (int i = 0; i < NBANKS; i++) begin
      cmram[i] = ~com_n && (int'(bank_q) == i);
    end
  end

  assign cmrom     = ~com_n & poc_n;
  assign op_ready  = (state_q == ST_IDLE);
  assign res_valid = rv_q;
  assign acc       = acc_q;
  assign cy        = cy_q;
  assign acc_zero  = (acc_q == '0);
  assign data_out  = dout_q;

endmodule

// File: tb/tb_alu_wide.sv
// Bench for alu_wide: 8-bit/4-bank instance against a behavioural model with
// random ops, plus a 16-bit/3-bank instance for long DAA and reset abort.
module tb_alu_wide;

  logic        sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // 8-bit, 4-bank instance
  logic        poc8_n, op_valid8, op_ready8, res_valid8, cy8, acc_zero8, com_n8, cmrom8;
  logic [3:0]  op_code8, cmram8;
  logic [7:0]  op_data8, acc8, data_out8;

  // 16-bit, 3-bank instance
  logic        poc16_n, op_valid16, op_ready16, res_valid16, cy16, acc_zero16, com_n16, cmrom16;
  logic [3:0]  op_code16;
  logic [2:0]  cmram16;
  logic [15:0] op_data16, acc16, data_out16;

  alu_wide #(.WIDTH(8), .NBANKS(4)) dut8 (
    .sysclk(sysclk), .poc_n(poc8_n), .op_valid(op_valid8), .op_ready(op_ready8),
    .op_code(op_code8), .op_data(op_data8), .res_valid(res_valid8), .acc(acc8),
    .cy(cy8), .acc_zero(acc_zero8), .data_out(data_out8), .com_n(com_n8),
    .cmram(cmram8), .cmrom(cmrom8)
  );

  alu_wide #(.WIDTH(16), .NBANKS(3)) dut16 (
    .sysclk(sysclk), .poc_n(poc16_n), .op_valid(op_valid16), .op_ready(op_ready16),
    .op_code(op_code16), .op_data(op_data16), .res_valid(res_valid16), .acc(acc16),
    .cy(cy16), .acc_zero(acc_zero16), .data_out(data_out16), .com_n(com_n16),
    .cmram(cmram16), .cmrom(cmrom16)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural state of the 8-bit instance
  int m_acc, m_cy, m_dout, m_bank;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kbp_ref(input int n);
    case (n)
      0: return 0;
      1: return 1;
      2: return 2;
      4: return 3;
      8: return 4;
      default: return 15;
    endcase
  endfunction

  task automatic model8(input int op, input int d);
    int s, c, nib;
    case (op)
      0: ;
      1: m_acc = d;
      2: begin m_dout = m_acc; m_acc = d; end
      3: begin s = m_acc + d + m_cy; m_acc = s % 256; m_cy = s / 256; end
      4: begin s = m_acc + (255 - d) + (1 - m_cy); m_acc = s % 256; m_cy = s / 256; end
      5: begin s = m_acc + 1; m_acc = s % 256; m_cy = s / 256; end
      6: begin m_cy = (m_acc != 0) ? 1 : 0; m_acc = (m_acc + 255) % 256; end
      7: begin m_acc = 0; m_cy = 0; end
      8: m_acc = 255 - m_acc;
      9: m_cy = 1 - m_cy;
      10: begin s = m_acc * 2 + m_cy; m_cy = s / 256; m_acc = s % 256; end
      11: begin s = m_cy * 256 + m_acc; m_cy = s % 2; m_acc = s / 2; end
      12: begin m_acc = m_cy; m_cy = 0; end
      13: begin
        // decimal adjust, low digit first, carry rippling up
        c = 0;
        for (int k = 0; k < 2; k++) begin
          nib = (m_acc >> (4 * k)) % 16 + c;
          if (nib > 9 || (k == 0 && m_cy == 1)) nib = nib + 6;
          c = nib / 16;
          m_acc = (m_acc & ~(15 << (4 * k))) | ((nib % 16) << (4 * k));
        end
        if (c == 1) m_cy = 1;
      end
      14: m_acc = kbp_ref(m_acc % 16);
      15: m_bank = m_acc % 4;
      default: ;
    endcase
  endtask

  // Issue one op to the 8-bit instance and check latency and the result.
  task automatic op8(input int op, input int d);
    int n;
    @(negedge sysclk);
    chk("rdy8", op_ready8, 1);
    op_valid8 = 1'b1;
    op_code8  = op[3:0];
    op_data8  = d[7:0];
    @(negedge sysclk);
    op_valid8 = 1'b0;
    model8(op, d);
    n = 1;
    while (res_valid8 !== 1'b1 && n < 10) begin
      @(negedge sysclk);
      n++;
    end
    chk($sformatf("lat8_op%0d", op), n, (op == 13) ? 2 : 1);
    chk($sformatf("acc8_op%0d", op), acc8, m_acc);
    chk($sformatf("cy8_op%0d", op), cy8, m_cy);
    chk($sformatf("dout8_op%0d", op), data_out8, m_dout);
    chk($sformatf("zero8_op%0d", op), acc_zero8, (m_acc == 0) ? 1 : 0);
    @(negedge sysclk);
    chk("rv8_pulse", res_valid8, 0);
  endtask

  task automatic op16(input int op, input int d, output int lat);
    int n;
    @(negedge sysclk);
    op_valid16 = 1'b1;
    op_code16  = op[3:0];
    op_data16  = d[15:0];
    @(negedge sysclk);
    op_valid16 = 1'b0;
    n = 1;
    while (res_valid16 !== 1'b1 && n < 12) begin
      @(negedge sysclk);
      n++;
    end
    lat = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, cnt;
    poc8_n = 1'b0; op_valid8 = 1'b0; op_code8 = '0; op_data8 = '0; com_n8 = 1'b1;
    poc16_n = 1'b0; op_valid16 = 1'b0; op_code16 = '0; op_data16 = '0; com_n16 = 1'b1;
    m_acc = 0; m_cy = 0; m_dout = 0; m_bank = 0;
    #12;
    chk("rst_acc", acc8, 0);
    chk("rst_cy", cy8, 0);
    chk("rst_dout", data_out8, 0);
    chk("rst_rv", res_valid8, 0);
    chk("rst_rdy", op_ready8, 1);
    chk("rst_cmrom", cmrom8, 0);
    @(negedge sysclk);
    poc8_n = 1'b1; poc16_n = 1'b1;

    // ADD with carry-in, then SUB with borrow
    op8(7, 0); op8(9, 0); op8(1, 'h9A);
    op8(3, 'h07);
    chk("add_acc", acc8, 'hA2); chk("add_cy", cy8, 0);
    op8(1, 'h05); op8(4, 'h07);
    chk("sub_acc", acc8, 'hFE); chk("sub_cy", cy8, 0);

    // Two-cycle DAA with an ignored request while busy
    op8(7, 0); op8(1, 'h9B);
    @(negedge sysclk);
    op_valid8 = 1'b1; op_code8 = 4'd13; op_data8 = 8'h00;
    @(negedge sysclk);
    chk("daa_busy", op_ready8, 0);
    chk("daa_rv_early", res_valid8, 0);
    op_code8 = 4'd1; op_data8 = 8'h55;
    @(negedge sysclk);
    op_valid8 = 1'b0;
    chk("daa_rv", res_valid8, 1);
    chk("daa_acc", acc8, 'h01);
    chk("daa_cy", cy8, 1);
    @(negedge sysclk);
    chk("daa_ignored", acc8, 'h01);
    chk("daa_rv_pulse", res_valid8, 0);
    m_acc = 'h01; m_cy = 1;

    // Rotates and inc/dec wrap
    op8(7, 0); op8(1, 'h81);
    op8(10, 0); chk("ral_acc", acc8, 'h02); chk("ral_cy", cy8, 1);
    op8(11, 0); chk("rar_acc", acc8, 'h81); chk("rar_cy", cy8, 0);
    op8(7, 0); op8(6, 0); chk("dac_acc", acc8, 'hFF); chk("dac_cy", cy8, 0);
    op8(5, 0); chk("iac_acc", acc8, 'h00); chk("iac_cy", cy8, 1);

    // KBP and XCH
    op8(1, 'h74); op8(14, 0); chk("kbp4", acc8, 'h03);
    op8(1, 'h16); op8(14, 0); chk("kbp6", acc8, 'h0F);
    op8(1, 'hF0); op8(14, 0); chk("kbp0", acc8, 'h00);
    op8(1, 'h33); op8(2, 'h5A);
    chk("xch_acc", acc8, 'h5A); chk("xch_dout", data_out8, 'h33);

    // Bank select and command gating
    op8(1, 2); op8(15, 0);
    com_n8 = 1'b0; #1;
    chk("cmram_b2", cmram8, 4'b0100); chk("cmrom_on", cmrom8, 1);
    com_n8 = 1'b1; #1;
    chk("cmram_off", cmram8, 0); chk("cmrom_off", cmrom8, 0);
    op8(1, 5); op8(15, 0);
    com_n8 = 1'b0; #1;
    chk("cmram_b5", cmram8, 4'b0010);

    // Random ops against the model
    for (int i = 0; i < 40; i++) begin
      op8($urandom_range(0, 15), $urandom_range(0, 255));
      chk("rnd_cmram", cmram8, 1 << m_bank);
    end

    // 16-bit: four-nibble DAA, then bank code beyond NBANKS
    op16(7, 0, lat); op16(1, 'h9A9A, lat);
    op16(13, 0, lat);
    chk("daa16_lat", lat, 4);
    chk("daa16_acc", acc16, 'h0100);
    chk("daa16_cy", cy16, 1);
    op16(1, 3, lat); op16(15, 0, lat);
    com_n16 = 1'b0; #1;
    chk("cmram3_b3", cmram16, 3'b000);

    // Reset in the middle of a 16-bit DAA aborts it
    op16(1, 'h9999, lat);
    @(negedge sysclk);
    op_valid16 = 1'b1; op_code16 = 4'd13;
    @(negedge sysclk);
    op_valid16 = 1'b0;
    chk("daa16_busy", op_ready16, 0);
    poc16_n = 1'b0; #1;
    chk("abort_acc", acc16, 0);
    chk("abort_cy", cy16, 0);
    chk("abort_rdy", op_ready16, 1);
    chk("abort_bank", cmram16, 3'b001);
    chk("abort_cmrom", cmrom16, 0);
    @(negedge sysclk);
    poc16_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      if (res_valid16 === 1'b1) cnt++;
    end
    chk("abort_no_rv", cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_wide.md
Name: alu_wide

Overview:
Parametrised successor to the 4004 accumulator/ALU datapath. It holds a WIDTH-bit accumulator plus carry and executes 4004-class accumulator ops on a valid/ready op interface. Multi-nibble decimal adjust (DAA) runs as a multi-cycle sequence, one nibble per cycle. A DCL-style bank register drives NBANKS one-hot CMRAM lines gated by com_n.

Parameters:
WIDTH, 4, accumulator/data width; multiple of 4, range 4..16; NNIB = WIDTH/4 derived.
NBANKS, 4, number of cmram outputs, 1..8; BANK_W = max(1, clog2(NBANKS)) derived.

Ports:
sysclk  in  1  system clock, all state on rising edge
poc_n  in  1  power-on clear, asynchronous, active-low
op_valid  in  1  op request
op_ready  out  1  block can accept an op this cycle
op_code  in  4  operation, encodings in package
op_data  in  WIDTH  operand (register/bus value)
res_valid  out  1  one-cycle pulse: acc/cy hold the completed result
acc  out  WIDTH  accumulator
cy  out  1  carry/link
acc_zero  out  1  acc == 0, combinational from acc
data_out  out  WIDTH  old accumulator captured by XCH
com_n  in  1  command strobe, active-low
cmram  out  NBANKS  one-hot RAM bank command lines
cmrom  out  1  ROM command line

Behaviour:
- Reset (poc_n=0, async): acc=0, cy=0, data_out=0, bank=0, res_valid=0, state=IDLE, op_ready=1. Reset during DAA_RUN aborts the sequence; no res_valid is issued.
- An op is accepted on a rising edge with op_valid & op_ready. op_ready = (state==IDLE). Requests while op_ready=0 are ignored and do not queue.
- Single-cycle ops update acc/cy on the accepting edge. res_valid is high for the following cycle.
- Ops; arithmetic is mod 2^WIDTH, and cy takes the carry-out of the WIDTH-bit sum:
  NOP 0: no change; res_valid still pulses.
  LD 1: acc<=op_data.
  XCH 2: acc<=op_data; data_out<=old acc. data_out is held until the next XCH.
  ADD 3: acc<=acc+op_data+cy.
  SUB 4: acc<=acc+~op_data+~cy. cy=1 means no borrow.
  IAC 5: acc<=acc+1; cy<=carry-out.
  DAC 6: acc<=acc-1; cy<=0 only when acc was 0, else 1.
  CLB 7: acc<=0, cy<=0.
  CMA 8: acc<=~acc.
  CMC 9: cy<=~cy.
  RAL 10: {cy,acc}<={acc,cy}.
  RAR 11: {acc,cy}<={cy,acc}.
  TCC 12: acc<=zero-extended cy; cy<=0.
  DAA 13: multi-cycle, see below.
  KBP 14: low nibble maps 0->0, 1->1, 2->2, 4->3, 8->4, any other value ->F; upper nibbles are cleared; cy is unchanged.
  DCL 15: bank<=acc[BANK_W-1:0]; acc/cy unchanged.
- DAA FSM, states IDLE and DAA_RUN, nibble index k:
  - Nibble k: s = acc[k] + cin_k, where cin_0 = 0.
  - If s>9, or (k==0 & cy), then s += 6.
  - acc[k] <= s[3:0]; cin_{k+1} = s[4].
  - Nibble 0 is processed on the accepting edge. If NNIB>1, go to DAA_RUN and process nibbles 1..NNIB-1 on subsequent edges, then return to IDLE.
  - cy<=1 if the final nibble carries out; otherwise cy is unchanged.
  - Total NNIB edges. res_valid pulses in the cycle after the last edge. For WIDTH=4, DAA timing equals a single-cycle op.
- cmram[i] = ~com_n & (bank==i). A bank value >= NBANKS drives all cmram lines 0.
- cmrom = ~com_n & poc_n.
- Unused op_code values do not exist (16/16 defined).

Decomposition:
- Package alu_wide_pkg holds:
  - op_code localparams OP_NOP..OP_DCL;
  - NIB=4 constant;
  - kbp_map function (nibble -> nibble);
  - state encoding ST_IDLE/ST_DAA_RUN.
- One sub-module, alu_wide_daa_nib: combinational 4-bit slice with inputs nib, cin, force6 and outputs nib_out, cout. It is instantiated once and multiplexed by k.

Test Plan:
- WIDTH=8. acc=0x9A, cy=1, ADD 0x07 -> acc=0xA2, cy=0, res_valid 1 cycle later. Then acc=0x05, cy=0, SUB 0x07 -> acc=0xFE, cy=0 (borrow).
- WIDTH=8. acc=0x9B, cy=0, DAA -> op_ready=0 for 1 cycle, acc=0x01, cy=1, res_valid 2 cycles after the accepting edge. A second op asserted during busy is ignored.
- acc=0x81, cy=0: RAL -> acc=0x02, cy=1; then RAR -> acc=0x81, cy=0. Also acc=0x00 DAC -> acc=0xFF, cy=0; acc=0xFF IAC -> acc=0x00, cy=1.
- KBP: acc low nibble 4 -> acc=0x03; 6 -> 0x0F; 0 -> 0x00. XCH 0x5A with acc=0x33 -> acc=0x5A, data_out=0x33.
- NBANKS=4. acc=2, DCL, com_n=0 -> cmram=0100, cmrom=1. com_n=1 -> all 0. Value 5 with BANK_W=2 selects bank 1 -> cmram=0010. Check NBANKS=3 with acc=3 -> cmram=000.
- Assert poc_n=0 mid-DAA (WIDTH=16) -> acc=0, cy=0, bank=0, op_ready=1 immediately, no res_valid.
